// File: rtl/demux_seq_pkg.sv
// Shared types and constants for the demux round-robin sequencer.
package demux_seq_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } seq_state_t;

    // Width needed to count 0..burst_len-1; never narrower than one bit.
    function automatic int beat_cnt_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin pick: first enabled channel after cur_ch, wrapping,
// falling back to cur_ch itself when it is the only one enabled.
module rr_next_ch
    import demux_seq_pkg::*;
(
    input  logic [SEL_W-1:0]  cur_ch,
    input  logic [CH_NUM-1:0] mask,
    output logic [SEL_W-1:0]  next_ch,
    output logic              none_en
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset to the nearest so the nearest enabled channel wins.
    always_comb begin
        next_ch = cur_ch;
        none_en = (mask == '0);
        cand    = cur_ch;
        for (int k = CH_NUM; k >= 1; k--) begin
            cand = cur_ch + SEL_W'(k);
            if (mask[cand]) begin
                next_ch = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sequencer.sv
// Round-robin feeder for a 1-to-4 demux: registered data/select/strobe, BURST_LEN beats per channel.
// Optional per-channel beat statistics are built when DEMUX_SEQ_STATS_EN is defined.
//
// state | meaning
// IDLE  | stopped; ready_o low, outputs hold
// RUN   | accepting beats for cur_ch
// SKIP  | one-cycle hop off a channel disabled mid-burst; partial burst dropped
module demux_rr_sequencer
    import demux_seq_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int START_CH  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [CH_NUM-1:0]       chan_en_i,
    input  logic                    data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    x_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    strobe_o,
    output logic                    burst_done_o
`ifdef DEMUX_SEQ_STATS_EN
    ,
    input  logic                    stats_clr_i,
    output logic [CH_NUM-1:0][15:0] beat_cnt_o
`endif
);

    localparam int               CNT_W     = beat_cnt_w(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [SEL_W-1:0] START_SEL = SEL_W'(START_CH);

    seq_state_t       state, state_nxt;
    logic [SEL_W-1:0] cur_ch, cur_ch_nxt, rr_ch;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             rr_none, go_idle, xfer, last_beat;

    rr_next_ch u_rr_next_ch (
        .cur_ch  (cur_ch),
        .mask    (chan_en_i),
        .next_ch (rr_ch),
        .none_en (rr_none)
    );

    assign go_idle   = !enable_i || (chan_en_i == '0);
    assign ready_o   = (state == RUN) && !go_idle;
    assign xfer      = valid_i && ready_o;
    assign last_beat = (beat_cnt == LAST_BEAT);

    always_comb begin
        state_nxt    = state;
        cur_ch_nxt   = cur_ch;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (!go_idle) begin
                    state_nxt = chan_en_i[cur_ch] ? RUN : SKIP;
                end
            end
            RUN: begin
                if (xfer && last_beat) begin
                    beat_cnt_nxt = '0;
                    cur_ch_nxt   = rr_ch;
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
                // A last beat already advances with the new mask, so it never needs SKIP.
                if (go_idle) begin
                    state_nxt = IDLE;
                end else if (!(xfer && last_beat) && !chan_en_i[cur_ch]) begin
                    state_nxt = SKIP;
                end
            end
            SKIP: begin
                beat_cnt_nxt = '0;
                if (!rr_none) begin
                    cur_ch_nxt = rr_ch;
                end
                state_nxt = go_idle ? IDLE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cur_ch   <= START_SEL;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cur_ch   <= cur_ch_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_o          <= 1'b0;
            sel_o        <= START_SEL;
            strobe_o     <= 1'b0;
            burst_done_o <= 1'b0;
        end else begin
            strobe_o     <= xfer;
            burst_done_o <= xfer && last_beat;
            if (xfer) begin
                x_o   <= data_i;
                sel_o <= cur_ch;
            end
        end
    end

`ifdef DEMUX_SEQ_STATS_EN
    // Counts beats as the demux sees them, i.e. from the registered strobe/select.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_o <= '0;
        end else begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (stats_clr_i) begin
                    beat_cnt_o[ch] <= '0;
                end else if (strobe_o && (sel_o == SEL_W'(ch)) && (beat_cnt_o[ch] != 16'hFFFF)) begin
                    beat_cnt_o[ch] <= beat_cnt_o[ch] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
